// File: rtl/clkdiv_sel.sv
// Multi-channel programmable clock divider with a glitch-free CPU clock selector.
// Every output is a register clocked by C100M; divider reloads only on half-period boundaries.
module clkdiv_sel #(
    parameter int NCH = 3,
    parameter int CW  = 8
) (
    input  logic                C100M,
    input  logic                RESETn,
    input  logic [NCH*CW-1:0]   DIV,
    input  logic                LOAD,
    input  logic [$clog2(NCH)-1:0] SEL,
    output logic [NCH-1:0]      CLKO,
    output logic                CLKCPU,
    output logic                BUSY
);

    localparam int SW = $clog2(NCH);

    typedef enum logic [1:0] {RUN, DRAIN, PARK} state_t;

    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0][CW-1:0] act_div;
    logic [NCH-1:0][CW-1:0] shadow;
    logic [NCH-1:0]         wrap;

    state_t          state, state_nx;
    logic [SW-1:0]   cur, cur_nx;
    logic [SW-1:0]   tgt, tgt_nx;
    logic            cpu_nx;
    logic            busy_nx;
    logic            sel_ok;

    always_comb begin
        wrap = '0;
        for (int i = 0; i < NCH; i++) begin
            wrap[i] = (cnt[i] == act_div[i]);
        end
    end

    // NOTE: the divider values are a small register file, but they are still reset so
    // every channel starts as a known divide-by-2 rather than an arbitrary rate.
    always_ff @(posedge C100M or negedge RESETn) begin
        if (!RESETn) begin
            cnt     <= '0;
            act_div <= '0;
            shadow  <= '0;
            CLKO    <= '0;
        end else begin
            if (LOAD) begin
                shadow <= DIV;
            end
            for (int i = 0; i < NCH; i++) begin
                if (wrap[i]) begin
                    cnt[i]     <= '0;
                    CLKO[i]    <= ~CLKO[i];
                    // A LOAD landing on the wrap cycle already governs the next half-period.
                    act_div[i] <= LOAD ? DIV[i*CW +: CW] : shadow[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sel_ok = (int'(SEL) < NCH);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge C100M or negedge RESETn) begin
        if (!RESETn) begin
            state  <= RUN;
            cur    <= '0;
            tgt    <= '0;
            CLKCPU <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_nx;
            cur    <= cur_nx;
            tgt    <= tgt_nx;
            CLKCPU <= cpu_nx;
            BUSY   <= busy_nx;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        tgt_nx   = tgt;
        busy_nx  = BUSY;
        cpu_nx   = 1'b0;
        case (state)
            RUN: begin
                cpu_nx = CLKO[cur];
                if (sel_ok && (SEL != cur)) begin
                    tgt_nx   = SEL;
                    busy_nx  = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Let the old clock finish its high phase, then park low.
                cpu_nx = CLKO[cur];
                if (!CLKO[cur]) begin
                    cpu_nx   = 1'b0;
                    state_nx = PARK;
                end
            end
            PARK: begin
                // Hand over only while the new clock is low so its next rise is whole.
                if (!CLKO[tgt]) begin
                    cur_nx   = tgt;
                    busy_nx  = 1'b0;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: doc/clkdiv_sel.md
CLKDIV_SEL -- requirements
Module: clkdiv_sel

Interface
REQ-001 SHALL have parameter NCH, default 3, number of divided clock channels (2..8).
REQ-002 SHALL have parameter CW, default 8, per-channel divider counter width.
REQ-003 SHALL have port C100M  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DIV  input  NCH*CW  half-period reload values; channel i at DIV[i*CW +: CW].
REQ-006 SHALL have port LOAD  input  1  one-cycle strobe capturing DIV into the shadow registers.
REQ-007 SHALL have port SEL  input  clog2(NCH)  requested CPU clock channel, sampled every cycle.
REQ-008 SHALL have port CLKO  output  NCH  divided clock outputs, registered.
REQ-009 SHALL have port CLKCPU  output  1  selected CPU clock, registered, glitch-free.
REQ-010 SHALL have port BUSY  output  1  high while a CPU clock switch is in progress.

Function
REQ-011 Per channel: counter counts 0..act_div[i]; on reaching act_div[i], the counter SHALL clear and CLKO[i] SHALL toggle.
REQ-012 Half-period SHALL be act_div[i]+1 cycles and period 2*(act_div[i]+1); act_div=0 gives divide-by-2.
REQ-013 On LOAD, all DIV fields SHALL be captured into shadow registers in that cycle.
REQ-014 Shadow value SHALL be copied into act_div[i] only on a channel-i wrap cycle, so no half-period is truncated.
REQ-015 LOAD coinciding with a channel-i wrap: the new DIV value SHALL govern the half-period starting after that wrap.
REQ-016 Channels SHALL run independently; no phase alignment between channels.
REQ-017 Switch FSM SHALL have states RUN, DRAIN, PARK; registers cur (active channel) and tgt (target channel).
REQ-018 RUN: CLKCPU <= CLKO[cur]; if SEL < NCH and SEL != cur then tgt <= SEL, BUSY <= 1, next state DRAIN.
REQ-019 DRAIN: CLKCPU <= CLKO[cur]; when CLKO[cur]==0 then CLKCPU <= 0, next state PARK.
REQ-020 PARK: CLKCPU SHALL be held 0; when CLKO[tgt]==0 then cur <= tgt, BUSY <= 0, next state RUN.
REQ-021 Latency: in RUN, CLKCPU SHALL equal CLKO[cur] delayed by exactly one cycle.
REQ-022 CLKCPU SHALL never produce a high or low phase shorter than the shorter half-period of the old and new channels.
REQ-023 SEL >= NCH SHALL be ignored: no state change, BUSY stays 0.
REQ-024 SEL changes while BUSY=1 SHALL be ignored; SEL is re-evaluated in RUN after the switch completes.
REQ-025 SEL == cur in RUN SHALL cause no action.

Reset
REQ-026 RESETn low SHALL immediately clear all counters, CLKO, CLKCPU and BUSY to 0.
REQ-027 Reset SHALL set act_div and shadow registers to 0, cur and tgt to 0, and the FSM to RUN.
REQ-028 Reset asserted mid-switch SHALL abort the switch; after release, CLKCPU follows CLKO[0].
REQ-029 Reset release to first CLKO[i] rise SHALL take act_div[i]+1 cycles.

Verification (NCH=3, CW=8)
REQ-030 Reset, then LOAD with DIV={3,1,0} (ch2,ch1,ch0) -> after the first wraps, CLKO0 period 2, CLKO1 period 4, CLKO2 period 8; CLKCPU = CLKO0 delayed 1 cycle.
REQ-031 LOAD ch2 DIV 3->9 two cycles into a ch2 half-period -> that half-period still lasts 4 cycles; all later ch2 half-periods last 10.
REQ-032 SEL 0->2 -> BUSY rises next cycle; CLKCPU drops with CLKO0 and stays low until CLKO2 is low; CLKCPU then tracks CLKO2; no CLKCPU pulse < 1 cycle high or low.
REQ-033 SEL=3 -> BUSY stays 0; CLKCPU keeps tracking the current channel.
REQ-034 SEL 0->2, then SEL->1 while BUSY=1 -> switch completes to 2, then a second switch 2->1 starts.
REQ-035 RESETn pulsed low during PARK -> CLKO=0, CLKCPU=0, BUSY=0 at once; after release, ch0 behaves as divide-by-2 and CLKCPU tracks CLKO0.
